// File: rtl/char_sequencer_pkg.sv
// rtl/char_sequencer_pkg.sv - shared types and defaults for the character sequencer
package char_sequencer_pkg;

    // Playback FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    localparam int CHAR_W             = 7;
    localparam int HOLD_W             = 8;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_HOLD_TICKS = 30;

endpackage

// File: rtl/char_buffer.sv
// rtl/char_buffer.sv - DEPTH x 7 message storage, one write port, combinational read
module char_buffer
    import char_sequencer_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [CHAR_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [CHAR_W-1:0] rd_data_o
);

    // Contents are never reset: entries beyond length are unreachable
    logic [CHAR_W-1:0] mem_q [DEPTH];

    // Store one character per accepted write
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/char_sequencer.sv
// rtl/char_sequencer.sv - plays a buffered message one character per HOLD_TICKS frames
module char_sequencer
    import char_sequencer_pkg::*;
#(
    parameter  int DEPTH      = DEFAULT_DEPTH,
    parameter  int HOLD_TICKS = DEFAULT_HOLD_TICKS,
    localparam int AW         = $clog2(DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tick60,
    input  logic              wr_valid,
    input  logic [CHAR_W-1:0] wr_char,
    output logic              wr_ready,
    input  logic              start,
    input  logic              loop_en,
    input  logic              clear,
    output logic              char_available,
    output logic [CHAR_W-1:0] char_out,
    output logic              busy,
    output logic [LW-1:0]     length
);

    seq_state_t        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [LW-1:0]     length_q, length_d;
    logic              char_available_q;
    logic [CHAR_W-1:0] char_out_q;
    logic              busy_q;
    logic              wr_ready_q;

    logic              wr_accept;
    logic              at_last;
    logic              hold_done;
    logic [CHAR_W-1:0] rd_data;

    // Writes only land when the registered ready was offered; clear wins
    assign wr_accept = wr_valid && wr_ready_q && !clear;
    assign at_last   = (LW'(idx_q) + LW'(1)) >= length_q;
    assign hold_done = (hold_q + HOLD_W'(1)) == HOLD_W'(HOLD_TICKS);

    // Read address follows the next index so char_out is loaded on entry to EMIT
    char_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk       (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (length_q[AW-1:0]),
        .wr_data_i (wr_char),
        .rd_addr_i (idx_d),
        .rd_data_o (rd_data)
    );

    // Next-state decode for the playback FSM, index, hold counter and length
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        length_d = length_q;
        if (clear) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            hold_d   = '0;
            length_d = '0;
        end else begin
            if (wr_accept) begin
                length_d = length_q + LW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start && (length_q != '0)) begin
                        state_d = ST_EMIT;
                        idx_d   = '0;
                    end
                end
                ST_EMIT: begin
                    // A tick landing on the strobe cycle is deliberately dropped
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (enable && tick60) begin
                        if (hold_done) begin
                            hold_d = '0;
                            if (!at_last) begin
                                idx_d   = idx_q + AW'(1);
                                state_d = ST_EMIT;
                            end else if (loop_en) begin
                                idx_d   = '0;
                                state_d = ST_EMIT;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset overrides everything including clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            hold_q           <= '0;
            length_q         <= '0;
            char_available_q <= 1'b0;
            char_out_q       <= '0;
            busy_q           <= 1'b0;
            wr_ready_q       <= 1'b1;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            hold_q           <= hold_d;
            length_q         <= length_d;
            char_available_q <= (state_d == ST_EMIT);
            if (clear) begin
                char_out_q <= '0;
            end else if (state_d == ST_EMIT) begin
                char_out_q <= rd_data;
            end
            busy_q           <= (state_d != ST_IDLE);
            wr_ready_q       <= (state_d == ST_IDLE) && (length_d != LW'(DEPTH));
        end
    end

    assign wr_ready       = wr_ready_q;
    assign char_available = char_available_q;
    assign char_out       = char_out_q;
    assign busy           = busy_q;
    assign length         = length_q;

endmodule

// File: tb/tb_char_sequencer.sv
// tb/tb_char_sequencer.sv - scoreboard bench for char_sequencer
module tb_char_sequencer;

    localparam int DEPTH = 16;
    localparam int HOLD  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          tick60;
    logic          wr_valid;
    logic [6:0]    wr_char;
    logic          wr_ready;
    logic          start;
    logic          loop_en;
    logic          clear;
    logic          char_available;
    logic [6:0]    char_out;
    logic          busy;
    logic [LW-1:0] length;

    typedef struct {
        logic [6:0] ch;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    char_sequencer #(
        .DEPTH      (DEPTH),
        .HOLD_TICKS (HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .tick60         (tick60),
        .wr_valid       (wr_valid),
        .wr_char        (wr_char),
        .wr_ready       (wr_ready),
        .start          (start),
        .loop_en        (loop_en),
        .clear          (clear),
        .char_available (char_available),
        .char_out       (char_out),
        .busy           (busy),
        .length         (length)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Frame ticks: one-cycle pulse every 4 clocks, changed on falling edges
    initial begin
        tick60 = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick60 = 1'b1;
            @(negedge clk);
            tick60 = 1'b0;
        end
    end

    // Monitor: after each rising edge, tick60 shows what that edge sampled
    initial begin
        int   tick_cnt;
        logic prev_strobe;
        exp_t e;
        tick_cnt    = 0;
        prev_strobe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick60 && !prev_strobe) tick_cnt++;
            if (char_available) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got char 0x%0h, expected no strobe", char_out);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_char", int'(char_out), int'(e.ch));
                    if (e.gap >= 0) check("strobe_gap_ticks", tick_cnt, e.gap);
                end
                tick_cnt = 0;
            end
            prev_strobe = char_available;
        end
    end

    task automatic wr(input logic [6:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", int'(busy), 0);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        wr_valid = 1'b0;
        wr_char  = '0;
        start    = 1'b0;
        loop_en  = 1'b0;
        clear    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_ready", int'(wr_ready), 1);
        check("rst_length", int'(length), 0);
        check("rst_char_out", int'(char_out), 0);
        check("rst_char_available", int'(char_available), 0);
        reset = 1'b0;
        @(negedge clk);

        // Start on an empty buffer is ignored
        pulse_start();
        check("empty_start_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("empty_start_busy_later", int'(busy), 0);

        // A, B, C played once, a second start mid-playback changes nothing
        wr(7'h41);
        wr(7'h42);
        wr(7'h43);
        check("abc_length", int'(length), 3);
        exp_q.push_back('{7'h41, -1});
        exp_q.push_back('{7'h42, HOLD});
        exp_q.push_back('{7'h43, HOLD});
        pulse_start();
        check("start_latency_strobe", int'(char_available), 1);
        check("start_latency_char", int'(char_out), 'h41);
        check("busy_after_start", int'(busy), 1);
        check("wr_ready_while_busy", int'(wr_ready), 0);
        repeat (3) @(negedge clk);
        pulse_start();
        wr(7'h55);
        wait_idle(200);
        wait_drain("abc_drained", 10);
        check("abc_length_kept", int'(length), 3);
        check("abc_last_char_held", int'(char_out), 'h43);

        // Fill to capacity, then an extra write is dropped
        pulse_clear();
        check("clear_length", int'(length), 0);
        check("clear_char_out", int'(char_out), 0);
        for (int i = 0; i < DEPTH; i++) wr(7'(8'h61 + i));
        check("full_wr_ready", int'(wr_ready), 0);
        check("full_length", int'(length), DEPTH);
        wr(7'h7a);
        check("overflow_length", int'(length), DEPTH);
        pulse_clear();
        check("clear_wr_ready", int'(wr_ready), 1);

        // Two characters looping, then clear while holding
        wr(7'h58);
        wr(7'h59);
        loop_en = 1'b1;
        exp_q.push_back('{7'h58, -1});
        exp_q.push_back('{7'h59, HOLD});
        exp_q.push_back('{7'h58, HOLD});
        exp_q.push_back('{7'h59, HOLD});
        exp_q.push_back('{7'h58, HOLD});
        pulse_start();
        wait_drain("loop_drained", 400);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("loop_clear_busy", int'(busy), 0);
        check("loop_clear_length", int'(length), 0);
        check("loop_clear_char_out", int'(char_out), 0);
        @(negedge clk);
        clear   = 1'b0;
        loop_en = 1'b0;
        repeat (20) @(negedge clk);

        // Enable held low for 10 ticks stretches the gap by 10 ticks
        wr(7'h50);
        wr(7'h51);
        exp_q.push_back('{7'h50, -1});
        exp_q.push_back('{7'h51, HOLD + 10});
        pulse_start();
        enable = 1'b0;
        @(posedge clk);
        begin
            int n = 0;
            int guard = 0;
            while (n < 10 && guard < 200) begin
                @(posedge clk);
                #1;
                guard++;
                if (tick60) n++;
            end
            check("enable_low_ticks_seen", n, 10);
        end
        enable = 1'b1;
        wait_idle(200);
        wait_drain("enable_drained", 10);

        // Reset in the middle of a hold
        exp_q.push_back('{7'h50, -1});
        pulse_start();
        check("rst_test_strobe", int'(char_available), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_length", int'(length), 0);
        check("midrst_char_out", int'(char_out), 0);
        check("midrst_char_available", int'(char_available), 0);
        check("midrst_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_sequencer.md
CHAR_SEQUENCER -- requirements
Module: char_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: message buffer capacity in characters; power of two, 2..64.
REQ-002 Parameter HOLD_TICKS, default 30: tick60 pulses each character is held before the next is sent; 1..255.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  when low, playback timing freezes; buffer writes still accepted.
REQ-006 tick60  input  1  one-clk pulse at the animation frame rate, from the shared clock divider.
REQ-007 wr_valid  input  1  append wr_char to the buffer.
REQ-008 wr_char  input  7  character code to append.
REQ-009 wr_ready  output  1  high when idle and buffer not full.
REQ-010 start  input  1  one-clk pulse; begins playback from index 0.
REQ-011 loop_en  input  1  sampled at end of message; high restarts playback at index 0.
REQ-012 clear  input  1  empties buffer and aborts playback.
REQ-013 char_available  output  1  one-clk strobe marking char_out valid; drives the animator's charAvailable.
REQ-014 char_out  output  7  current character code; drives the animator's charInput.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 length  output  $clog2(DEPTH)+1  number of stored characters.

Function
REQ-017 FSM states: IDLE, EMIT, HOLD.
REQ-018 IDLE -> EMIT on start when length>0; start with length==0 is ignored and the FSM stays in IDLE.
REQ-019 EMIT lasts exactly one clk: char_available=1, char_out=buf[idx], hold counter cleared, then -> HOLD.
REQ-020 HOLD: counter increments on each tick60 while enable=1; when the count reaches HOLD_TICKS, -> EMIT with idx+1 if idx<length-1.
REQ-021 At the last index with the count reaching HOLD_TICKS: loop_en=1 -> EMIT with idx=0; loop_en=0 -> IDLE.
REQ-022 Latency: char_available rises in the clk after start is sampled; successive strobes are exactly HOLD_TICKS tick60 pulses apart while enable=1.
REQ-023 char_out holds the last emitted code until the next EMIT; it is 0 before the first emit and after clear.
REQ-024 A write is accepted only when wr_valid && wr_ready; it stores wr_char at buf[length] and increments length in the same edge.
REQ-025 Writes while busy or full are dropped silently; length saturates at DEPTH.
REQ-026 clear has priority over start, wr_valid and tick60: length=0, idx=0, char_out=0, FSM -> IDLE on the next edge.
REQ-027 start while busy is ignored; it does not restart playback.
REQ-028 A tick60 coincident with EMIT is not counted.
REQ-029 enable=0 in EMIT still completes the strobe; the FSM then waits in HOLD.

Reset
REQ-030 reset forces FSM=IDLE, idx=0, hold counter=0, length=0, char_out=0, char_available=0, busy=0, wr_ready=1.
REQ-031 reset takes priority over all inputs, including mid-playback and clear.
REQ-032 Buffer contents need no reset; they are unreachable until rewritten because length=0.

Structure
REQ-033 The state encoding and the DEPTH and HOLD_TICKS defaults SHALL reside in the shared project package, reused by the top level.
REQ-034 One sub-module, char_buffer, SHALL provide the DEPTH x 7 storage with write port and combinational read port; FSM, counters and handshake stay in char_sequencer.
REQ-035 Outputs SHALL be registered; char_available SHALL NOT be combinational from inputs.

Verification
REQ-036 Write 'A','B','C' (0x41,0x42,0x43), HOLD_TICKS=2, start, loop_en=0 -> strobes with 0x41, 0x42, 0x43, each 2 ticks apart, then busy=0.
REQ-037 Write 16 characters, then a 17th -> wr_ready=0 after the 16th, the 17th is dropped, length=16.
REQ-038 Two characters, loop_en=1 -> strobe sequence 0,1,0,1 continuing; clear mid-HOLD -> IDLE next clk, length=0, char_out=0.
REQ-039 start with empty buffer -> no strobe, busy stays 0; start pulsed while busy -> sequence timing unchanged.
REQ-040 enable=0 for 10 ticks during HOLD -> next strobe delayed by exactly 10 ticks; reset mid-HOLD -> all REQ-030 values next clk.
